// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, WIDTH+1 cycle issue.
// start/busy/done handshake; d and borrow update only on the completion edge.
module serial_subtractor #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             bin;
  logic [CW-1:0]    cnt;

  logic ai;
  logic bi;
  logic diff_c;
  logic bnext_c;

  // Full-subtractor cell on the current LSBs
  assign ai      = a_sh[0];
  assign bi      = b_sh[0];
  assign diff_c  = ai ^ bi ^ bin;
  assign bnext_c = (~ai & bi) | (~(ai ^ bi) & bin);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE doubles as an accept slot so back-to-back issue runs at WIDTH+1 cycles
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            r_sh  <= '0;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r_sh <= {diff_c, r_sh[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          bin  <= bnext_c;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            d      <= {diff_c, r_sh[WIDTH-1:1]};
            borrow <= bnext_c;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed/sweep bench for serial_subtractor at WIDTH=3 and WIDTH=8.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       sel;
  logic       start3, start8;
  logic [2:0] a3, b3;
  logic [7:0] a8, b8;
  logic       busy3, done3, borrow3;
  logic       busy8, done8, borrow8;
  logic [2:0] d3;
  logic [7:0] d8;

  logic        busy_m, done_m, borrow_m;
  logic [31:0] d_m;

  int n_chk;
  int n_pass;

  serial_subtractor #(.WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .d(d3), .borrow(borrow3)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .d(d8), .borrow(borrow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    busy_m   = sel ? busy8   : busy3;
    done_m   = sel ? done8   : done3;
    borrow_m = sel ? borrow8 : borrow3;
    d_m      = sel ? 32'(d8) : 32'(d3);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive(input logic st, input logic [31:0] av, input logic [31:0] bv);
    if (sel) begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start3 = st; a3 = av[2:0]; b3 = bv[2:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation on the selected instance, checked against a - b
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] prevd;
    logic [63:0] exp;
    logic [63:0] got;
    int cyc;
    int bcnt;
    prevd = d_m;
    drive(1'b1, av, bv);
    tick();
    drive(1'b0, 32'(0), 32'(0));
    cyc  = 0;
    bcnt = 0;
    while (!done_m && cyc < 20) begin
      check("busy_done_excl", 64'(busy_m & done_m), 64'(0));
      check("d_hold", 64'(d_m), 64'(prevd));
      if (busy_m) bcnt++;
      tick();
      cyc++;
    end
    exp = (64'(av) - 64'(bv)) & ((64'd1 << (w + 1)) - 64'd1);
    got = (64'(borrow_m) << w) | 64'(d_m);
    check("done_seen", 64'(done_m), 64'(1));
    check("latency", 64'(cyc), 64'(w));
    check("busy_cycles", 64'(bcnt), 64'(w));
    check("busy_at_done", 64'(busy_m), 64'(0));
    check("result", got, exp);
    tick();
    check("done_pulse", 64'(done_m), 64'(0));
    check("busy_after", 64'(busy_m), 64'(0));
    check("d_held", got, (64'(borrow_m) << w) | 64'(d_m));
  endtask

  logic [2:0] av_seq [12];
  logic [2:0] bv_seq [12];

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; sel = 1'b0;
    start3 = 1'b0; start8 = 1'b0;
    a3 = '0; b3 = '0; a8 = '0; b8 = '0;
    av_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    bv_seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd3, 3'd3, 3'd3, 3'd3};

    // Reset state, with start asserted to show reset wins
    start3 = 1'b1; start8 = 1'b1;
    tick(); tick();
    check("rst_busy3", 64'(busy3), 64'(0));
    check("rst_done3", 64'(done3), 64'(0));
    check("rst_d3", 64'(d3), 64'(0));
    check("rst_borrow3", 64'(borrow3), 64'(0));
    check("rst_busy8", 64'(busy8), 64'(0));
    check("rst_d8", 64'(d8), 64'(0));
    start3 = 1'b0; start8 = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_no_start", 64'(busy3), 64'(0));

    // Directed vectors with hand-computed results
    run_op(3, 32'd5, 32'd3);
    check("hand_5m3_d", 64'(d_m), 64'd2);
    check("hand_5m3_b", 64'(borrow_m), 64'd0);
    run_op(3, 32'd3, 32'd5);
    check("hand_3m5_d", 64'(d_m), 64'd6);
    check("hand_3m5_b", 64'(borrow_m), 64'd1);
    run_op(3, 32'd0, 32'd7);
    check("hand_0m7_d", 64'(d_m), 64'd1);
    check("hand_0m7_b", 64'(borrow_m), 64'd1);
    run_op(3, 32'd7, 32'd7);
    check("hand_7m7_d", 64'(d_m), 64'd0);
    check("hand_7m7_b", 64'(borrow_m), 64'd0);

    // start held high: accepts at offsets 0,4,8; done at 3,7,11
    for (int i = 0; i < 12; i++) begin
      start3 = 1'b1; a3 = av_seq[i]; b3 = bv_seq[i];
      tick();
      check("b2b_done", 64'(done3), 64'((i % 4) == 3));
      check("b2b_busy", 64'(busy3), 64'((i % 4) != 3));
      if ((i % 4) == 3)
        check("b2b_result", 64'({borrow3, d3}),
              64'(4'({1'b0, av_seq[i-3]} - {1'b0, bv_seq[i-3]})));
    end
    start3 = 1'b0;
    tick();
    check("b2b_d_last", 64'({borrow3, d3}), 64'({1'b1, 3'd6}));
    tick();
    check("b2b_idle", 64'(busy3), 64'(0));

    // Reset during the second RUN cycle aborts without a done pulse
    run_op(3, 32'd6, 32'd1);
    check("pre_abort_d", 64'(d3), 64'd5);
    drive(1'b1, 32'd5, 32'd3);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    tick();
    check("abort_running", 64'(busy3), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy3), 64'(0));
    check("abort_d", 64'(d3), 64'(0));
    check("abort_borrow", 64'(borrow3), 64'(0));
    for (int i = 0; i < 5; i++) begin
      check("abort_no_done", 64'(done3), 64'(0));
      tick();
    end
    run_op(3, 32'd5, 32'd3);
    check("post_abort_d", 64'(d3), 64'd2);

    // Exhaustive WIDTH=3
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        run_op(3, 32'(x), 32'(y));

    // Random plus corner sweep at WIDTH=8
    sel = 1'b1;
    run_op(8, 32'd0, 32'd255);
    check("w8_0m255", 64'({borrow8, d8}), 64'({1'b1, 8'd1}));
    run_op(8, 32'd255, 32'd0);
    check("w8_255m0", 64'({borrow8, d8}), 64'({1'b0, 8'd255}));
    for (int k = 0; k < 40; k++)
      run_op(8, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
